mod_n_clock_divider: RTL and testbench

- Parametrised runtime-programmable modulo-N counter and clock divider. Generalises the fixed divide-by-6/12 ripple counter to WIDTH bits with a loadable modulus, enable, and a one-cycle tick strobe.
- Also produces a registered near-50%-duty divided clock-enable waveform and drives the board LEDs with the live count.
- Sits between the 100 MHz board clock and slower blocks (LED blinkers, debouncers, display scanners).

---
 rtl/mod_n_clock_divider_if.sv | 24 ++
 rtl/mod_n_clock_divider.sv | 99 +++++++++
 tb/tb_mod_n_clock_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mod_n_clock_divider_if.sv
// Control/status bundle for the modulo-N divider.
// master: the block that programs the divider; slave: the divider itself.
interface mod_n_clock_divider_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             mod_load;
   logic [WIDTH-1:0] mod_in;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             clk_div;
   logic             err;
   logic [3:0]       led;

   modport master (
      output en, mod_load, mod_in,
      input  count, tick, clk_div, err, led
   );

   modport slave (
      input  en, mod_load, mod_in,
      output count, tick, clk_div, err, led
   );
endinterface

// File: rtl/mod_n_clock_divider.sv
// Runtime-programmable modulo-N counter / clock divider.
// A new modulus waits in a pending register and only takes effect at a wrap,
// so the period in progress always completes with the old modulus.
// clk_div is high for ceil(M/2) counts of each period, aligned with count.
// Optional: define MOD_DIV_SYNC_CLEAR_EN to add a synchronous clear input sclr.
module mod_n_clock_divider #(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_MOD = 12
) (
   input  logic                 CLK,
   input  logic                 RESET,
`ifdef MOD_DIV_SYNC_CLEAR_EN
   input  logic                 sclr,
`endif
   mod_n_clock_divider_if.slave bus
);

   localparam logic [WIDTH-1:0] DEF_M = WIDTH'(DEFAULT_MOD);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] count_q, mod_q, pend_q;
   logic [WIDTH-1:0] cnt_nxt, mod_nxt, hi_len;
   logic             pend_vld, tick_q, clk_div_q, err_q;
   logic             wrap, adv, apply, load_ok, load_bad, clr;

`ifdef MOD_DIV_SYNC_CLEAR_EN
   assign clr = sclr;
`else
   assign clr = 1'b0;
`endif

   // Next count and next modulus; a clear freezes counting and blocks the wrap-apply
   always_comb begin
      wrap     = (count_q == mod_q - ONE);
      adv      = bus.en & ~clr;
      apply    = adv & wrap;
      load_ok  = bus.mod_load & (bus.mod_in != '0);
      load_bad = bus.mod_load & (bus.mod_in == '0);
      cnt_nxt  = count_q;
      mod_nxt  = mod_q;
      if (adv) begin
         if (wrap) begin
            cnt_nxt = '0;
            // A load arriving on the wrap cycle beats an older pending value
            if (load_ok)       mod_nxt = bus.mod_in;
            else if (pend_vld) mod_nxt = pend_q;
         end else begin
            cnt_nxt = count_q + ONE;
         end
      end
      hi_len = mod_nxt - (mod_nxt >> 1);
   end

   // Counter, modulus, pending slot, strobes and sticky error
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count_q   <= '0;
         mod_q     <= DEF_M;
         pend_q    <= '0;
         pend_vld  <= 1'b0;
         tick_q    <= 1'b0;
         clk_div_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         mod_q <= mod_nxt;
         if (load_bad) err_q <= 1'b1;
         if (apply) begin
            pend_vld <= 1'b0;
         end else if (load_ok) begin
            pend_q   <= bus.mod_in;
            pend_vld <= 1'b1;
         end
         if (clr) begin
            count_q   <= '0;
            tick_q    <= 1'b0;
            clk_div_q <= 1'b1;
         end else begin
            count_q   <= cnt_nxt;
            tick_q    <= apply;
            clk_div_q <= (cnt_nxt < hi_len);
         end
      end
   end

   assign bus.count   = count_q;
   assign bus.tick    = tick_q;
   assign bus.clk_div = clk_div_q;
   assign bus.err     = err_q;

   // LEDs show the low nibble of the live count
   generate
      if (WIDTH >= 4) begin : g_led_wide
         assign bus.led = count_q[3:0];
      end else begin : g_led_narrow
         assign bus.led = {{(4 - WIDTH){1'b0}}, count_q};
      end
   endgenerate

endmodule

// File: tb/tb_mod_n_clock_divider.sv
// Directed test for mod_n_clock_divider (WIDTH=4, DEFAULT_MOD=12).
module tb_mod_n_clock_divider;

   logic CLK;
   logic RESET;
`ifdef MOD_DIV_SYNC_CLEAR_EN
   logic sclr;
`endif
   int cmp_cnt = 0;
   int mis_cnt = 0;

   mod_n_clock_divider_if #(.WIDTH(4)) bus ();

   mod_n_clock_divider #(.WIDTH(4), .DEFAULT_MOD(12)) dut (
      .CLK   (CLK),
      .RESET (RESET),
`ifdef MOD_DIV_SYNC_CLEAR_EN
      .sclr  (sclr),
`endif
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock and check the registered outputs on the falling edge
   task automatic cyc(input int c, input logic t, input logic d);
      logic [31:0] cv;
      cv = c;
      @(negedge CLK);
      chk("count",   bus.count,   cv);
      chk("tick",    bus.tick,    t);
      chk("clk_div", bus.clk_div, d);
      chk("led",     bus.led,     cv & 32'hF);
   endtask

   task automatic async_reset();
      #2 RESET = 1'b0;
      #1;
      chk("rst_count",   bus.count,   0);
      chk("rst_tick",    bus.tick,    0);
      chk("rst_clk_div", bus.clk_div, 1);
      chk("rst_err",     bus.err,     0);
      chk("rst_led",     bus.led,     0);
   endtask

   initial begin
      RESET = 1'b0;
      bus.en = 1'b0;
      bus.mod_load = 1'b0;
      bus.mod_in = '0;
`ifdef MOD_DIV_SYNC_CLEAR_EN
      sclr = 1'b0;
`endif
      // Reset held for 3 cycles
      repeat (3) @(negedge CLK);
      chk("reset_count",   bus.count,   0);
      chk("reset_tick",    bus.tick,    0);
      chk("reset_clk_div", bus.clk_div, 1);
      chk("reset_err",     bus.err,     0);

      // Default M=12: 0..11, tick on wrap, 6 high / 6 low
      RESET = 1'b1;
      bus.en = 1'b1;
      for (int n = 1; n <= 15; n++) cyc(n % 12, (n % 12) == 0, (n % 12) < 6);
      // count=3: request M=5; current period finishes with M=12
      bus.mod_load = 1'b1;
      bus.mod_in = 4'd5;
      cyc(4, 0, 1);
      bus.mod_load = 1'b0;
      for (int n = 5; n <= 12; n++) cyc(n % 12, (n % 12) == 0, (n % 12) < 6);
      // M=5: 3 high / 2 low
      for (int i = 1; i <= 10; i++) cyc(i % 5, (i % 5) == 0, (i % 5) < 3);

      // Illegal modulus 0: err sticky, period unchanged
      bus.mod_load = 1'b1;
      bus.mod_in = 4'd0;
      cyc(1, 0, 1);
      chk("err_set", bus.err, 1);
      bus.mod_load = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         cyc(i % 5, (i % 5) == 0, (i % 5) < 3);
         chk("err_sticky", bus.err, 1);
      end
      async_reset();

      // Load on the wrap cycle takes effect at that wrap
      @(negedge CLK);
      RESET = 1'b1;
      for (int n = 1; n <= 11; n++) cyc(n, 0, n < 6);
      bus.mod_load = 1'b1;
      bus.mod_in = 4'd3;
      cyc(0, 1, 1);
      bus.mod_load = 1'b0;
      for (int i = 1; i <= 6; i++) cyc(i % 3, (i % 3) == 0, (i % 3) < 2);
      async_reset();

      // Enable low holds everything
      @(negedge CLK);
      RESET = 1'b1;
      for (int n = 1; n <= 4; n++) cyc(n, 0, 1);
      bus.en = 1'b0;
      for (int i = 0; i < 7; i++) cyc(4, 0, 1);
      bus.en = 1'b1;
      for (int n = 5; n <= 9; n++) cyc(n, 0, n < 6);
      // Reset at count=9 with clk_div low: clears without a clock edge
      async_reset();

      // M=1: constant clk_div, tick every enabled cycle
      @(negedge CLK);
      RESET = 1'b1;
      bus.mod_load = 1'b1;
      bus.mod_in = 4'd1;
      cyc(1, 0, 1);
      bus.mod_load = 1'b0;
      for (int n = 2; n <= 12; n++) cyc(n % 12, (n % 12) == 0, (n % 12) < 6);
      for (int i = 0; i < 4; i++) cyc(0, 1, 1);

`ifdef MOD_DIV_SYNC_CLEAR_EN
      // Synchronous clear at count=7: no tick, count restarts
      async_reset();
      @(negedge CLK);
      RESET = 1'b1;
      for (int n = 1; n <= 7; n++) cyc(n, 0, n < 6);
      sclr = 1'b1;
      cyc(0, 0, 1);
      sclr = 1'b0;
      cyc(1, 0, 1);
      cyc(2, 0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
